// File: rtl/seg7_scan_decoder.sv
// Receiver for a 4-digit multiplexed 7-segment bus: debounces and captures each digit, then converts the frame to BCD and binary.
// Latency: valid pulses 5 clocks after the edge that captures the last missing digit; the conversion itself takes 4 iterations.
// Backpressure: none; capture continues while converting, and a frame that fills during a conversion starts once the FSM is idle.
//
// Ports:
//   clk, rst_n     single rising-edge clock, asynchronous active-low reset
//   seg_n[6:0]     active-low segments, bit0 = a .. bit6 = g
//   an_n[3:0]      active-low anodes, an_n[3] = most-significant digit
//   bcd[15:0]      last converted frame {d3,d2,d1,d0}
//   value[13:0]    binary value of the last frame (0 when err)
//   valid          one-cycle pulse when bcd/value/err update
//   err            last frame held an undecodable pattern
//   busy           conversion in progress
module seg7_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  an_n,
    output logic [15:0] bcd,
    output logic [13:0] value,
    output logic        valid,
    output logic        err,
    output logic        busy
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    typedef enum logic {IDLE, CONV} state_t;

    state_t            state;
    state_t            state_nxt;

    logic [3:0]        prev_an;
    logic [6:0]        prev_seg;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic [3:0]        mask;
    logic [3:0]        mask_nxt;
    logic [3:0][3:0]   slot_dig;
    logic [3:0]        slot_bad;
    logic [3:0][3:0]   snap_dig;
    logic [3:0]        snap_bad;
    logic [13:0]       acc;
    logic [13:0]       acc_nxt;
    logic [1:0]        idx;

    logic              elig;
    logic              prev_elig;
    logic              new_dwell;
    logic              capture;
    logic [1:0]        slot;
    logic [3:0]        dec_dig;
    logic              dec_bad;
    logic              start;
    logic              finish;

    function automatic logic one_low(input logic [3:0] a);
        return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
    endfunction

    // Segment pattern to digit; anything unrecognised becomes Fh and is flagged.
    always_comb begin
        dec_bad = 1'b0;
        case (seg_n)
            7'h40:   dec_dig = 4'd0;
            7'h79:   dec_dig = 4'd1;
            7'h24:   dec_dig = 4'd2;
            7'h30:   dec_dig = 4'd3;
            7'h19:   dec_dig = 4'd4;
            7'h12:   dec_dig = 4'd5;
            7'h02:   dec_dig = 4'd6;
            7'h78:   dec_dig = 4'd7;
            7'h00:   dec_dig = 4'd8;
            7'h10:   dec_dig = 4'd9;
            default: begin
                dec_dig = 4'hF;
                dec_bad = 1'b1;
            end
        endcase
    end

    always_comb begin
        case (an_n)
            4'b0111: slot = 2'd3;
            4'b1011: slot = 2'd2;
            4'b1101: slot = 2'd1;
            default: slot = 2'd0;
        endcase
    end

    // Stability tracking. The previous sample resets to all-zero anodes,
    // which is ineligible, so the first eligible sample starts a new dwell.
    always_comb begin
        elig      = one_low(an_n);
        prev_elig = one_low(prev_an);
        new_dwell = !(prev_elig && (an_n == prev_an) && (seg_n == prev_seg));
        if (!elig)
            cnt_nxt = 4'd0;
        else if (new_dwell)
            cnt_nxt = 4'd1;
        else if (cnt == STABLE)
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + 4'd1;
        // Capture only on the transition into STABLE; a saturated dwell
        // never recaptures (covers STABLE_CYCLES = 1 via new_dwell).
        capture = elig && (cnt_nxt == STABLE) && (new_dwell || (cnt != STABLE));
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (mask == 4'hF) begin
                    start     = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (idx == 2'd0) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A capture on the same edge as the frame start survives the clear.
    always_comb begin
        mask_nxt = start ? 4'h0 : mask;
        if (capture)
            mask_nxt[slot] = 1'b1;
        acc_nxt = (acc << 3) + (acc << 1) + {10'd0, snap_dig[idx]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_an  <= 4'h0;
            prev_seg <= 7'h0;
            cnt      <= 4'd0;
            mask     <= 4'h0;
            slot_dig <= '0;
            slot_bad <= 4'h0;
            snap_dig <= '0;
            snap_bad <= 4'h0;
            acc      <= 14'd0;
            idx      <= 2'd0;
            bcd      <= 16'h0;
            value    <= 14'd0;
            valid    <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            prev_an  <= an_n;
            prev_seg <= seg_n;
            cnt      <= cnt_nxt;
            mask     <= mask_nxt;
            valid    <= finish;
            if (capture) begin
                slot_dig[slot] <= dec_dig;
                slot_bad[slot] <= dec_bad;
            end
            if (start) begin
                snap_dig <= slot_dig;
                snap_bad <= slot_bad;
                acc      <= 14'd0;
                idx      <= 2'd3;
                busy     <= 1'b1;
            end else if (state == CONV) begin
                acc <= acc_nxt;
                idx <= idx - 2'd1;
                if (finish) begin
                    bcd   <= snap_dig;
                    value <= (|snap_bad) ? 14'd0 : acc_nxt;
                    err   <= |snap_bad;
                    busy  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Sequential receiver for the four-digit multiplexed seven-segment display bus that the board's display path drives. It samples the active-low anode and segment lines, captures each digit's pattern once it has been stable, and decodes the pattern back to BCD. Once all four digits of a frame are captured, it converts them to a 14-bit binary value over four clocks. It sits at the monitor/loopback end of the display path and is used for self-check and readback.

## Interface
Parameters:
- STABLE_CYCLES, default 4: number of consecutive identical samples (same anode, same segments) required to capture a digit. Legal range 1..15.

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- seg_n  input  7  segment lines, active-low; bit0 = a … bit6 = g
- an_n  input  4  anode lines, active-low; an_n[3] selects the most-significant digit
- bcd  output  16  last converted frame, {d3,d2,d1,d0}, 4 bits per digit
- value  output  14  binary value of the last frame, 0..9999
- valid  output  1  one-cycle pulse when bcd, value and err update
- err  output  1  last frame contained an undecodable pattern; qualified by valid, held until the next update
- busy  output  1  conversion in progress

## Operation
- Pattern decode (active-low):
  - 0: 40h
  - 1: 79h
  - 2: 24h
  - 3: 30h
  - 4: 19h
  - 5: 12h
  - 6: 02h
  - 7: 78h
  - 8: 00h
  - 9: 10h
  - Any other pattern decodes to digit Fh and is flagged invalid.
- Sampling: each cycle, register {an_n, seg_n} as the previous sample.
  - A sample is eligible only if an_n has exactly one bit low.
  - All-high (blanking) or multiple-low samples are ineligible and clear the stability counter to 0.
- Stability counter (4 bits):
  - An eligible sample that differs from the previous sample, or follows an ineligible one, sets the counter to 1.
  - An eligible sample equal to the previous sample increments the counter, saturating at STABLE_CYCLES.
- Capture: on the edge where the counter reaches STABLE_CYCLES, store the decoded digit and its invalid flag in the slot selected by an_n, and set that slot's bit in the 4-bit capture mask.
  - Capture happens once per dwell. The pattern must change or blank before it can recapture.
  - Recapturing a slot before the frame completes overwrites it; the latest capture wins.
- FSM states: IDLE, CONV.
  - IDLE → CONV when the mask is 1111b.
  - On that edge: snapshot the four digits and flags, clear the mask, set acc = 0, set idx = 3.
  - CONV, each edge: acc ← acc·10 + digit[idx], computed as (acc<<3)+(acc<<1)+digit, 14-bit wide, no overflow possible for valid digits. Then idx decrements.
  - On the edge processing idx = 0:
    - update bcd to the snapshot.
    - If no snapshot flag is set, value ← final acc and err ← 0.
    - If any flag is set, value ← 0 and err ← 1.
    - Pulse valid and return to IDLE.
- Capture continues during CONV into the freshly cleared mask. If the mask fills while busy, the start waits until IDLE.
- A capture and the mask clear can occur on the same edge. In that case the mask becomes exactly the new capture's bit.
- Reset (asynchronous, any state), all to zero:
  - bcd = 0, value = 0, valid = 0, err = 0, busy = 0
  - mask, counter, previous sample, digit slots
  - FSM → IDLE
  - A conversion interrupted by reset produces no valid pulse.

## Timing
- Edge T captures the last missing digit, so the mask reads 1111b after T.
- Edge T+1: enter CONV; busy rises.
- Edges T+2, T+3, T+4, T+5: iterations for idx 3, 2, 1, 0.
- Edge T+5: outputs update, valid = 1 for exactly one cycle, busy falls.
- Latency from the last capture edge to valid high is 5 clocks. The earliest next CONV entry is edge T+6.
- Minimum dwell per digit is STABLE_CYCLES clocks. A full frame needs at least 4·STABLE_CYCLES clocks of eligible samples.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst_n low mid-run → all outputs 0 immediately, asynchronously; after release with no input activity, no valid pulse.
- Frame 1234, STABLE_CYCLES=4: hold each digit for 4 cycles:
  - an_n=0111 with 79h
  - an_n=1011 with 24h
  - an_n=1101 with 30h
  - an_n=1110 with 19h

  Expected: valid 5 clocks after the fourth capture, value=1234 (4D2h), bcd=1234h, err=0.
- Frame 9999 (10h on all anodes) → value=9999 (270Fh), bcd=9999h, err=0. Then frame 0000 (40h) → value=0, bcd=0000h.
- Glitch/ineligible: hold digit 3 for only 3 cycles, and drive an_n=0000 for 10 cycles → no capture, no valid. Completing a proper frame afterwards gives the correct value.
- Invalid pattern: digits 9,9,9 with 7Fh on an_n=1110 → valid, err=1, value=0, bcd=999Fh.
- Reset during CONV (rst_n low at T+3) → busy and valid are 0, no pulse follows. The next complete frame converts correctly.
